// File: rtl/uart_rx_if.sv
// Byte-side bundle of the 8N1 receiver: holding register contents, valid/ready
// handshake and the two single-cycle error pulses.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    // Receiver side drives the byte and status; the consumer drives ready.
    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples serial_rxd on the system clock, checks start and
// stop bits and hands each byte over through a one-entry valid/ready holding register.
module uart_rx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      serial_rxd,
    uart_rx_if.master rx
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_STOP    = 3'd3;
    localparam logic [2:0] ST_DELIVER = 3'd4;
    localparam logic [2:0] ST_BREAK   = 3'd5;

    logic             rx_meta;
    logic             rxs;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       idx;
    logic [2:0]       idx_nxt;
    logic [7:0]       sh;
    logic [7:0]       sh_nxt;
    logic             stop_bad;
    logic             deliver;

    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic             frame_err_q;
    logic             overrun_q;

    // Two-flop synchronizer; resetting to 1 makes the line look idle after reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= serial_rxd;
            rxs     <= rx_meta;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        sh_nxt    = sh;
        stop_bad  = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (!rxs) state_nxt = ST_START;
            end

            // Sample near the middle of the start bit; a high line there was a glitch.
            ST_START: begin
                if (cnt == HALF_CNT) begin
                    cnt_nxt = '0;
                    if (!rxs) begin
                        idx_nxt   = '0;
                        state_nxt = ST_DATA;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (cnt == FULL_CNT) begin
                    cnt_nxt = '0;
                    sh_nxt  = {rxs, sh[7:1]};
                    if (idx == 3'd7) state_nxt = ST_STOP;
                    else             idx_nxt   = idx + 3'd1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (cnt == FULL_CNT) begin
                    cnt_nxt = '0;
                    if (rxs) begin
                        state_nxt = ST_DELIVER;
                    end else begin
                        stop_bad  = 1'b1;
                        state_nxt = ST_BREAK;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            ST_DELIVER: state_nxt = ST_IDLE;

            // A line held low after a bad stop bit must go high before a new frame can start.
            ST_BREAK: begin
                if (rxs) state_nxt = ST_IDLE;
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
        end else begin
            // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            sh    <= sh_nxt;
        end
    end

    assign deliver = (state == ST_DELIVER);

    // Holding register: a load in DELIVER wins over a same-cycle accept, so valid stays high.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= stop_bad;
            overrun_q   <= 1'b0;
            if (deliver) begin
                if (!rx_valid_q || rx.rx_ready) begin
                    rx_data_q  <= sh;
                    rx_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && rx.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx.rx_data   = rx_data_q;
    assign rx.rx_valid  = rx_valid_q;
    assign rx.frame_err = frame_err_q;
    assign rx.overrun   = overrun_q;

endmodule
